memory_port_arbiter: RTL and testbench

// - Shares one 32-bit memory port (enable/ready four-phase handshake) between two requesters
//   (port 0 = instruction fetch, port 1 = data/load-store) with round-robin arbitration.
// - Rejects misaligned or invalid-size accesses locally with a fault, without touching memory.
// - Sits between the CPU's memory requesters and the RAM model/controller.

---
 rtl/memory_port_arbiter.sv | 120 ++++++++++++
 tb/tb_memory_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit enable/ready memory port between an
// instruction-fetch requester (port 0) and a load/store requester (port 1).
module memory_port_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] port0_address,
  input  logic [31:0] port0_data_out,
  input  logic [1:0]  port0_data_size,
  input  logic        port0_operation,
  input  logic        port0_enable,
  output logic [31:0] port0_data_in,
  output logic        port0_ready,
  output logic        port0_fault,
  input  logic [31:0] port1_address,
  input  logic [31:0] port1_data_out,
  input  logic [1:0]  port1_data_size,
  input  logic        port1_operation,
  input  logic        port1_enable,
  output logic [31:0] port1_data_in,
  output logic        port1_ready,
  output logic        port1_fault,
  output logic [31:0] memory_address,
  output logic [31:0] memory_data_out,
  output logic [1:0]  memory_data_size,
  output logic        memory_operation,
  output logic        memory_enable,
  input  logic [31:0] memory_data_in,
  input  logic        memory_ready
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t           state;
  logic             grant, last_grant;
  logic [1:0]       en, op, rdy, flt;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][1:0]  size;
  logic             pick;

  assign en    = {port1_enable, port0_enable};
  assign op    = {port1_operation, port0_operation};
  assign addr  = {port1_address, port0_address};
  assign wdata = {port1_data_out, port0_data_out};
  assign size  = {port1_data_size, port0_data_size};

  assign port0_ready   = rdy[0];
  assign port1_ready   = rdy[1];
  assign port0_fault   = flt[0];
  assign port1_fault   = flt[1];
  assign port0_data_in = rdata[0];
  assign port1_data_in = rdata[1];

  // On a tie the port that did not win last time goes first.
  assign pick = (en == 2'b11) ? ~last_grant : en[1];

  function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = (a[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] zext(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    zext = {24'b0, d[7:0]};
      2'd1:    zext = {16'b0, d[15:0]};
      default: zext = d;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= 1'b0;
      last_grant       <= 1'b1;
      rdy              <= '0;
      flt              <= '0;
      rdata            <= '0;
      memory_address   <= '0;
      memory_data_out  <= '0;
      memory_data_size <= '0;
      memory_operation <= 1'b0;
      memory_enable    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|en) begin
          grant            <= pick;
          last_grant       <= pick;
          memory_address   <= addr[pick];
          memory_data_out  <= wdata[pick];
          memory_data_size <= size[pick];
          memory_operation <= op[pick];
          if (misaligned(addr[pick], size[pick])) begin
            rdy[pick] <= 1'b1;
            flt[pick] <= 1'b1;
            state     <= RELEASE;
          end else begin
            memory_enable <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: if (memory_ready) begin
          memory_enable <= 1'b0;
          rdy[grant]    <= 1'b1;
          flt[grant]    <= 1'b0;
          if (!memory_operation)
            rdata[grant] <= zext(memory_data_in, memory_data_size);
          state <= RELEASE;
        end
        RELEASE: if (!en[grant] && !memory_ready) begin
          rdy[grant] <= 1'b0;
          flt[grant] <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench: requests push expected completions/memory transactions,
// monitors pop and compare on ready and memory_enable rising edges.
module tb_memory_port_arbiter;
  logic        clock = 0, reset = 1;
  logic [31:0] p_addr [2], p_wd [2];
  logic [1:0]  p_sz [2];
  logic        p_op [2], p_en [2];
  logic [31:0] port0_data_in, port1_data_in;
  logic        port0_ready, port1_ready, port0_fault, port1_fault;
  logic [31:0] memory_address, memory_data_out, memory_data_in;
  logic [1:0]  memory_data_size;
  logic        memory_operation, memory_enable, memory_ready;

  memory_port_arbiter dut (
    .clock(clock), .reset(reset),
    .port0_address(p_addr[0]), .port0_data_out(p_wd[0]), .port0_data_size(p_sz[0]),
    .port0_operation(p_op[0]), .port0_enable(p_en[0]), .port0_data_in(port0_data_in),
    .port0_ready(port0_ready), .port0_fault(port0_fault),
    .port1_address(p_addr[1]), .port1_data_out(p_wd[1]), .port1_data_size(p_sz[1]),
    .port1_operation(p_op[1]), .port1_enable(p_en[1]), .port1_data_in(port1_data_in),
    .port1_ready(port1_ready), .port1_fault(port1_fault),
    .memory_address(memory_address), .memory_data_out(memory_data_out),
    .memory_data_size(memory_data_size), .memory_operation(memory_operation),
    .memory_enable(memory_enable), .memory_data_in(memory_data_in),
    .memory_ready(memory_ready)
  );

  always #5 clock = ~clock;

  typedef struct { int port; logic fault; bit chk_data; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; logic [1:0] size; logic op; logic [31:0] wdata; } mexp_t;
  exp_t  exp_q [$];
  mexp_t mq [$];

  int errors = 0, checks = 0, men_rises = 0, mem_lat = 3;
  logic [31:0] mem_rdata = 32'h0;

  wire [1:0]       rdy_v = {port1_ready, port0_ready};
  wire [1:0]       flt_v = {port1_fault, port0_fault};
  wire [1:0][31:0] din_v = {port1_data_in, port0_data_in};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: raises ready mem_lat negedges after enable, drops it once enable drops.
  initial begin
    int cnt = 0;
    memory_ready = 0;
    memory_data_in = 32'h5A5A5A5A;
    forever begin
      @(negedge clock);
      if (!memory_enable) begin
        memory_ready = 0;
        cnt = 0;
      end else if (!memory_ready) begin
        cnt++;
        if (cnt >= mem_lat) begin
          memory_ready = 1;
          memory_data_in = mem_rdata;
        end
      end
    end
  end

  // Monitor: compares completions and memory transactions against the queues.
  initial begin
    logic [1:0] prev_rdy = '0;
    logic prev_men = 0;
    exp_t e;
    mexp_t m;
    forever begin
      @(negedge clock);
      if (!reset) begin
        for (int p = 0; p < 2; p++)
          if (rdy_v[p] && !prev_rdy[p]) begin
            if (exp_q.size() == 0) chk("unexpected_ready", 32'(p), 32'hFFFFFFFF);
            else begin
              e = exp_q.pop_front();
              chk("resp_port", 32'(p), 32'(e.port));
              chk("resp_fault", 32'(flt_v[p]), 32'(e.fault));
              if (e.chk_data) chk("resp_data", din_v[p], e.data);
            end
          end
        if (memory_enable && !prev_men) begin
          men_rises++;
          if (mq.size() == 0) chk("unexpected_mem_enable", memory_address, 32'hFFFFFFFF);
          else begin
            m = mq.pop_front();
            chk("mem_addr", memory_address, m.addr);
            chk("mem_size", 32'(memory_data_size), 32'(m.size));
            chk("mem_op", 32'(memory_operation), 32'(m.op));
            if (m.op) chk("mem_wdata", memory_data_out, m.wdata);
          end
        end
      end
      prev_rdy = rdy_v;
      prev_men = memory_enable;
    end
  end

  function automatic void push(input int p, input logic f, input bit cd, input logic [31:0] d);
    exp_t e;
    e.port = p; e.fault = f; e.chk_data = cd; e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void mpush(input logic [31:0] a, input logic [1:0] s, input logic o,
                                input logic [31:0] w);
    mexp_t m;
    m.addr = a; m.size = s; m.op = o; m.wdata = w;
    mq.push_back(m);
  endfunction

  // Called just after a negedge; holds the request until ready, then drops it.
  task automatic do_req(input int p, input logic [31:0] a, input logic [1:0] sz,
                        input logic op, input logic [31:0] wd, input bit chk_lat);
    int n = 0;
    p_addr[p] = a; p_sz[p] = sz; p_op[p] = op; p_wd[p] = wd; p_en[p] = 1;
    if (chk_lat) begin
      @(negedge clock);
      chk("mem_enable_latency", 32'(memory_enable), 32'd1);
    end
    while (!rdy_v[p] && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!rdy_v[p]) chk("ready_timeout", 32'(p), 32'hFFFFFFFF);
    p_en[p] = 0;
    @(negedge clock);
    chk("ready_clear", 32'(rdy_v[p]), 32'd0);
  endtask

  initial begin
    int n, rises;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises;
    for (int p = 0; p < 2; p++) begin
      p_addr[p] = 0; p_wd[p] = 0; p_sz[p] = 0; p_op[p] = 0; p_en[p] = 0;
    end
    repeat (3) @(negedge clock);
    chk("reset_mem", {memory_address, memory_data_out} , 64'h0);
    chk("reset_mem_ctl", {29'b0, memory_enable, memory_operation, |memory_data_size}, 32'h0);
    chk("reset_ports", {26'b0, rdy_v, flt_v, |port0_data_in, |port1_data_in}, 32'h0);
    reset = 0;
    @(negedge clock);

    // Tie from reset: port 0 first, then port 1; a second tie again favours port 0.
    mem_rdata = 32'h01020304;
    push(0, 0, 1, 32'h01020304); mpush(32'h0, 2, 0, 0);
    push(1, 0, 0, 0);            mpush(32'h2000, 2, 1, 32'h12345678);
    fork
      do_req(0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
      do_req(1, 32'h2000, 2'd2, 1'b1, 32'h12345678, 1'b0);
    join
    push(0, 0, 1, 32'h01020304); mpush(32'h4, 2, 0, 0);
    push(1, 0, 1, 32'h01020304); mpush(32'h2004, 2, 0, 0);
    fork
      do_req(0, 32'h4, 2'd2, 1'b0, 32'h0, 1'b0);
      do_req(1, 32'h2004, 2'd2, 1'b0, 32'h0, 1'b0);
    join

    // Word read, memory_enable one cycle after request.
    mem_rdata = 32'hDEADBEEF;
    push(0, 0, 1, 32'hDEADBEEF); mpush(32'h100, 2, 0, 0);
    do_req(0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b1);

    // Local faults never reach memory.
    rises = men_rises;
    push(1, 1, 0, 0); do_req(1, 32'h201, 2'd1, 1'b0, 32'h0, 1'b0);
    push(0, 1, 0, 0); do_req(0, 32'h102, 2'd2, 1'b0, 32'h0, 1'b0);
    push(0, 1, 0, 0); do_req(0, 32'h100, 2'd3, 1'b1, 32'h0, 1'b0);
    chk("fault_no_mem", 32'(men_rises), 32'(rises));

    // Zero extension of byte and half reads.
    mem_rdata = 32'hAABBCC7F;
    push(0, 0, 1, 32'h0000007F); mpush(32'h3, 0, 0, 0);
    do_req(0, 32'h3, 2'd0, 1'b0, 32'h0, 1'b0);
    push(1, 0, 1, 32'h0000CC7F); mpush(32'h202, 1, 0, 0);
    do_req(1, 32'h202, 2'd1, 1'b0, 32'h0, 1'b0);

    // Continuous port 0 traffic; port 1 gets the second slot.
    mem_rdata = 32'hCAFEF00D;
    push(0, 0, 1, 32'hCAFEF00D); mpush(32'h10, 2, 0, 0);
    push(1, 0, 0, 0);            mpush(32'h3000, 2, 1, 32'h0000A5A5);
    push(0, 0, 1, 32'hCAFEF00D); mpush(32'h14, 2, 0, 0);
    push(0, 0, 1, 32'hCAFEF00D); mpush(32'h18, 2, 0, 0);
    fork
      begin
        do_req(0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0);
        do_req(0, 32'h14, 2'd2, 1'b0, 32'h0, 1'b0);
        do_req(0, 32'h18, 2'd2, 1'b0, 32'h0, 1'b0);
      end
      begin
        repeat (2) @(negedge clock);
        do_req(1, 32'h3000, 2'd2, 1'b1, 32'h0000A5A5, 1'b0);
      end
    join

    // Reset two cycles into an access.
    mem_lat = 20;
    mpush(32'h40, 2, 0, 0);
    p_addr[0] = 32'h40; p_sz[0] = 2; p_op[0] = 0; p_en[0] = 1;
    n = 0;
    while (!memory_enable && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("abort_access_started", 32'(memory_enable), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1; p_en[0] = 0;
    @(negedge clock);
    chk("abort_mem_enable", 32'(memory_enable), 32'd0);
    chk("abort_ready_fault", {28'b0, rdy_v, flt_v}, 32'h0);
    reset = 0;
    mem_lat = 3;
    repeat (2) @(negedge clock);
    mem_rdata = 32'h600DF00D;
    push(0, 0, 1, 32'h600DF00D); mpush(32'h80, 2, 0, 0);
    push(1, 0, 1, 32'h600DF00D); mpush(32'h84, 2, 0, 0);
    fork
      do_req(0, 32'h80, 2'd2, 1'b0, 32'h0, 1'b0);
      do_req(1, 32'h84, 2'd2, 1'b0, 32'h0, 1'b0);
    join

    repeat (3) @(negedge clock);
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
